// File: rtl/tlb_pkg.sv
// Shared types and default widths for the TLB entry array and its helpers.
package tlb_pkg;

  localparam int unsigned TlbEntries = 8;
  localparam int unsigned TlbVpnW    = 27;
  localparam int unsigned TlbPpnW    = 44;
  localparam int unsigned TlbAsidW   = 16;

  typedef struct packed {
    logic                valid;
    logic                is_global;
    logic [TlbVpnW-1:0]  vpn;
    logic [TlbAsidW-1:0] asid;
    logic [TlbPpnW-1:0]  ppn;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StDone
  } flush_state_e;

endpackage

// File: rtl/tlb_victim_sel.sv
// Fill target selection: matching entry first, then lowest invalid slot, then PLRU victim.
module tlb_victim_sel
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = TlbEntries
) (
  input  logic [ENTRIES-1:0]         valid_i,
  input  logic [ENTRIES-1:0]         match_i,
  input  logic [$clog2(ENTRIES)-1:0] plru_victim_i,
  output logic [$clog2(ENTRIES)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [IdxW-1:0] match_idx;
  logic [IdxW-1:0] free_idx;
  logic            match_found;
  logic            free_found;

  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    // Descending scan so the lowest index is the last one assigned.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        match_idx = IdxW'(i);
      end
      if (!valid_i[i]) begin
        free_idx = IdxW'(i);
      end
    end
    match_found = |match_i;
    free_found  = ~&valid_i;
    if (match_found) begin
      idx_o = match_idx;
    end else if (free_found) begin
      idx_o = free_idx;
    end else begin
      idx_o = plru_victim_i;
    end
  end

endmodule

// File: rtl/tlb_entry_array.sv
// Fully-associative TLB storage: one-cycle lookups, fills with PLRU reporting,
// and a sequential, optionally ASID-filtered flush sweep.
module tlb_entry_array
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = TlbEntries,
  parameter int unsigned VPN_W   = TlbVpnW,
  parameter int unsigned PPN_W   = TlbPpnW,
  parameter int unsigned ASID_W  = TlbAsidW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       lu_req_i,
  input  logic [VPN_W-1:0]           lu_vpn_i,
  input  logic [ASID_W-1:0]          lu_asid_i,
  output logic                       lu_valid_o,
  output logic                       lu_hit_o,
  output logic [PPN_W-1:0]           lu_ppn_o,
  output logic [$clog2(ENTRIES)-1:0] lu_idx_o,
  input  logic                       fill_valid_i,
  output logic                       fill_ready_o,
  input  logic [VPN_W-1:0]           fill_vpn_i,
  input  logic [ASID_W-1:0]          fill_asid_i,
  input  logic [PPN_W-1:0]           fill_ppn_i,
  input  logic                       fill_global_i,
  output logic                       plru_hit_o,
  output logic [$clog2(ENTRIES)-1:0] plru_idx_o,
  input  logic [$clog2(ENTRIES)-1:0] plru_victim_i,
  input  logic                       flush_i,
  input  logic                       flush_asid_valid_i,
  input  logic [ASID_W-1:0]          flush_asid_i,
  output logic                       flush_done_o
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  // Entry field widths come from the package defaults.
  tlb_entry_t entries_q [ENTRIES];

  flush_state_e      state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic              flush_asid_valid_q, flush_asid_valid_d;
  logic [ASID_W-1:0] flush_asid_q, flush_asid_d;

  logic [ENTRIES-1:0] valid_vec;
  logic [ENTRIES-1:0] lu_match;
  logic [ENTRIES-1:0] fill_match;
  logic [IdxW-1:0]    lu_match_idx;
  logic [PPN_W-1:0]   lu_match_ppn;
  logic [IdxW-1:0]    fill_idx;
  logic               lu_hit_en;
  logic               fill_fire;
  logic               flush_kill;
  tlb_entry_t         fill_entry;

  logic              lu_valid_q, lu_valid_d;
  logic              lu_hit_q, lu_hit_d;
  logic [PPN_W-1:0]  lu_ppn_q, lu_ppn_d;
  logic [IdxW-1:0]   lu_idx_q, lu_idx_d;
  logic              plru_hit_q, plru_hit_d;
  logic [IdxW-1:0]   plru_idx_q, plru_idx_d;

  always_comb begin
    valid_vec  = '0;
    lu_match   = '0;
    fill_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i]  = entries_q[i].valid;
      lu_match[i]   = entries_q[i].valid && (entries_q[i].vpn == lu_vpn_i) &&
                      (entries_q[i].is_global || (entries_q[i].asid == lu_asid_i));
      fill_match[i] = entries_q[i].valid && (entries_q[i].vpn == fill_vpn_i) &&
                      (entries_q[i].is_global || fill_global_i ||
                       (entries_q[i].asid == fill_asid_i));
    end
  end

  always_comb begin
    lu_match_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lu_match[i]) begin
        lu_match_idx = lu_match_idx | IdxW'(i);
      end
    end
  end

  assign lu_match_ppn = entries_q[lu_match_idx].ppn;

  tlb_victim_sel #(
    .ENTRIES(ENTRIES)
  ) u_victim_sel (
    .valid_i      (valid_vec),
    .match_i      (fill_match),
    .plru_victim_i(plru_victim_i),
    .idx_o        (fill_idx)
  );

  // Flush FSM
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    flush_asid_valid_d = flush_asid_valid_q;
    flush_asid_d       = flush_asid_q;
    fill_ready_o       = 1'b0;
    flush_done_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        fill_ready_o = 1'b1;
        if (flush_i) begin
          state_d            = StFlush;
          cnt_d              = '0;
          flush_asid_valid_d = flush_asid_valid_i;
          flush_asid_d       = flush_asid_i;
        end
      end
      StFlush: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IdxW'(ENTRIES - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        flush_done_o = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign fill_fire  = fill_valid_i && fill_ready_o;
  assign lu_hit_en  = lu_req_i && (state_q == StIdle) && (|lu_match);
  assign flush_kill = (state_q == StFlush) && !entries_q[cnt_q].is_global &&
                      (!flush_asid_valid_q || (entries_q[cnt_q].asid == flush_asid_q));

  always_comb begin
    fill_entry.valid     = 1'b1;
    fill_entry.is_global = fill_global_i;
    fill_entry.vpn       = fill_vpn_i;
    fill_entry.asid      = fill_asid_i;
    fill_entry.ppn       = fill_ppn_i;
  end

  // Result and PLRU report registers; a fill takes precedence over a lookup hit.
  always_comb begin
    lu_valid_d = lu_req_i;
    lu_hit_d   = lu_hit_en;
    lu_ppn_d   = lu_hit_en ? lu_match_ppn : '0;
    lu_idx_d   = lu_hit_en ? lu_match_idx : '0;
    plru_hit_d = fill_fire || lu_hit_en;
    plru_idx_d = '0;
    if (fill_fire) begin
      plru_idx_d = fill_idx;
    end else if (lu_hit_en) begin
      plru_idx_d = lu_match_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      flush_asid_valid_q <= 1'b0;
      flush_asid_q       <= '0;
      lu_valid_q         <= 1'b0;
      lu_hit_q           <= 1'b0;
      lu_ppn_q           <= '0;
      lu_idx_q           <= '0;
      plru_hit_q         <= 1'b0;
      plru_idx_q         <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      flush_asid_valid_q <= flush_asid_valid_d;
      flush_asid_q       <= flush_asid_d;
      lu_valid_q         <= lu_valid_d;
      lu_hit_q           <= lu_hit_d;
      lu_ppn_q           <= lu_ppn_d;
      lu_idx_q           <= lu_idx_d;
      plru_hit_q         <= plru_hit_d;
      plru_idx_q         <= plru_idx_d;
    end
  end

  // Fills only happen in StIdle and kills only in StFlush, so they never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      if (fill_fire) begin
        entries_q[fill_idx] <= fill_entry;
      end
      if (flush_kill) begin
        entries_q[cnt_q].valid <= 1'b0;
      end
    end
  end

  assign lu_valid_o = lu_valid_q;
  assign lu_hit_o   = lu_hit_q;
  assign lu_ppn_o   = lu_ppn_q;
  assign lu_idx_o   = lu_idx_q;
  assign plru_hit_o = plru_hit_q;
  assign plru_idx_o = plru_idx_q;

  lu_single_match_a : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(lu_match));

endmodule
